// File: rtl/axis_bdim_pattern_source.sv
// rtl/axis_bdim_pattern_source.sv - AXI-Stream source emitting NUM_BLOCKS blocks of BDIM patterned beats
// Patterns: constant, incrementing, LFSR or block index; tlast closes every block.
module axis_bdim_pattern_source #(
  parameter int DATA_WIDTH = 8,
  parameter int BDIM       = 8,
  parameter int NUM_BLOCKS = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] m_axis_output0_tdata,
  output logic                  m_axis_output0_tvalid,
  input  logic                  m_axis_output0_tready,
  output logic                  m_axis_output0_tlast
);

  localparam int EW = (BDIM > 1) ? $clog2(BDIM) : 1;
  localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int XW = (BW > DATA_WIDTH) ? BW : DATA_WIDTH;
  localparam logic [EW-1:0] ELEM_LAST = EW'(BDIM - 1);
  localparam logic [BW-1:0] BLK_LAST  = BW'(NUM_BLOCKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [1:0]      mode_q;
  logic [EW-1:0]   elem_cnt;
  logic [BW-1:0]   blk_cnt;

  logic                  elem_wrap;
  logic                  final_beat;
  logic [EW-1:0]         elem_nxt;
  logic [BW-1:0]         blk_nxt;
  logic [DATA_WIDTH-1:0] data_nxt;
  logic [DATA_WIDTH-1:0] seed_init;

  // Block index is zero-extended or truncated to the data width.
  function automatic logic [DATA_WIDTH-1:0] blk_to_data(input logic [BW-1:0] b);
    logic [XW-1:0] x;
    x = XW'(b);
    return x[DATA_WIDTH-1:0];
  endfunction

  always_comb begin
    elem_wrap  = (elem_cnt == ELEM_LAST);
    final_beat = elem_wrap && (blk_cnt == BLK_LAST);
    elem_nxt   = elem_wrap ? '0 : elem_cnt + EW'(1);
    blk_nxt    = elem_wrap ? blk_cnt + BW'(1) : blk_cnt;
    case (mode_q)
      2'd0:    data_nxt = m_axis_output0_tdata;
      2'd1:    data_nxt = m_axis_output0_tdata + DATA_WIDTH'(1);
      2'd2:    data_nxt = {m_axis_output0_tdata[DATA_WIDTH-2:0],
                           m_axis_output0_tdata[DATA_WIDTH-1] ^ m_axis_output0_tdata[DATA_WIDTH-2]};
      default: data_nxt = blk_to_data(blk_nxt);
    endcase
  end

  // A zero seed would lock the LFSR, so it is replaced by 1.
  always_comb begin
    case (cfg_mode)
      2'd2:    seed_init = (cfg_seed == '0) ? DATA_WIDTH'(1) : cfg_seed;
      2'd3:    seed_init = '0;
      default: seed_init = cfg_seed;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state                 <= S_IDLE;
      mode_q                <= '0;
      elem_cnt              <= '0;
      blk_cnt               <= '0;
      busy                  <= 1'b0;
      done                  <= 1'b0;
      m_axis_output0_tdata  <= '0;
      m_axis_output0_tvalid <= 1'b0;
      m_axis_output0_tlast  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mode_q                <= cfg_mode;
            m_axis_output0_tdata  <= seed_init;
            elem_cnt              <= '0;
            blk_cnt               <= '0;
            m_axis_output0_tvalid <= 1'b1;
            m_axis_output0_tlast  <= (BDIM == 1);
            busy                  <= 1'b1;
            state                 <= S_RUN;
          end
        end
        S_RUN: begin
          if (m_axis_output0_tvalid && m_axis_output0_tready) begin
            if (final_beat) begin
              m_axis_output0_tvalid <= 1'b0;
              m_axis_output0_tlast  <= 1'b0;
              busy                  <= 1'b0;
              done                  <= 1'b1;
              state                 <= S_DONE;
            end else begin
              elem_cnt             <= elem_nxt;
              blk_cnt              <= blk_nxt;
              m_axis_output0_tdata <= data_nxt;
              m_axis_output0_tlast <= (elem_nxt == ELEM_LAST);
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
